// File: rtl/mem_read_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_fsm
// Summary  : Burst memory reader. Issues NWORDS sequential reads and packs the
//            returned words into DataBuff, first word in the MS slice.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_fsm #(
  parameter int NWORDS = 16,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     Clk1,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [ADDR_W-1:0]        AddrIn,
  input  logic [WORD_W-1:0]        DataOut,
  output logic [ADDR_W-1:0]        Addr,
  output logic                     RD,
  output logic [NWORDS*WORD_W-1:0] DataBuff,
  output logic                     Busy,
  output logic                     Done
);

  localparam int               CNT_W  = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_rd;
  logic [ADDR_W-1:0]        r_addr;
  logic [NWORDS*WORD_W-1:0] r_buf;
  logic                     w_ret_vld;
  logic [CNT_W-1:0]         w_ret_idx;
  logic                     w_last_issue;
  logic                     w_last_ret;
  logic                     w_launch;

  assign w_launch     = (r_state == S_IDLE) && Start;
  assign w_last_issue = (r_state == S_ISSUE) && (r_cnt == C_LAST);
  assign w_last_ret   = w_ret_vld && (w_ret_idx == C_LAST);

  always_ff @(posedge Clk1) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = (RD_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (w_last_ret) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address/strobe are registered; Addr holds its last value after the burst.
  always_ff @(posedge Clk1) begin
    if (Rst) begin
      r_addr <= '0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_launch) begin
      r_addr <= AddrIn;
      r_rd   <= 1'b1;
      r_cnt  <= '0;
    end else if (r_state == S_ISSUE) begin
      if (w_last_issue) begin
        r_rd <= 1'b0;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  generate
    if (RD_LAT == 0) begin : g_comb_rd
      assign w_ret_vld = r_rd;
      assign w_ret_idx = r_cnt;
    end else begin : g_rd_pipe
      logic [RD_LAT-1:0] r_pv;
      logic [CNT_W-1:0]  r_pi [RD_LAT];

      always_ff @(posedge Clk1) begin
        if (Rst) begin
          r_pv <= '0;
          for (int k = 0; k < RD_LAT; k++) r_pi[k] <= '0;
        end else begin
          r_pv[0] <= r_rd;
          r_pi[0] <= r_cnt;
          for (int k = 1; k < RD_LAT; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pi[k] <= r_pi[k-1];
          end
        end
      end

      assign w_ret_vld = r_pv[RD_LAT-1];
      assign w_ret_idx = r_pi[RD_LAT-1];
    end
  endgenerate

  // Each return writes only its own slice; word 0 lands in the MS slice.
  always_ff @(posedge Clk1) begin
    if (Rst) begin
      r_buf <= '0;
    end else begin
      for (int i = 0; i < NWORDS; i++) begin
        if (w_ret_vld && (w_ret_idx == CNT_W'(i)))
          r_buf[(NWORDS-1-i)*WORD_W +: WORD_W] <= DataOut;
      end
    end
  end

  assign Addr     = r_addr;
  assign RD       = r_rd;
  assign DataBuff = r_buf;
  assign Busy     = (r_state != S_IDLE);
  assign Done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_read_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_read_fsm
// Summary  : Bench for mem_read_fsm at RD_LAT = 0, 1 and 3 sharing one memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_read_fsm;

  localparam int NW = 16;
  localparam int BW = NW * 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [15:0]   addr_in;
  logic [15:0]   dout  [3];
  logic [15:0]   addr  [3];
  logic          rd    [3];
  logic [BW-1:0] buff  [3];
  logic          busy  [3];
  logic          done  [3];

  logic [15:0]   mem   [65536];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    mem_read_fsm #(.NWORDS(NW), .WORD_W(16), .ADDR_W(16), .RD_LAT(L)) u_dut (
      .Clk1(clk), .Rst(rst), .Start(start), .AddrIn(addr_in), .DataOut(dout[g]),
      .Addr(addr[g]), .RD(rd[g]), .DataBuff(buff[g]), .Busy(busy[g]), .Done(done[g])
    );

    if (L == 0) begin : g_comb_mem
      assign dout[g] = mem[addr[g]];
    end else begin : g_pipe_mem
      logic [15:0] dp [L];
      always @(posedge clk) begin
        dp[0] <= mem[addr[g]];
        for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
      end
      assign dout[g] = dp[L-1];
    end
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  // Expected buffer: word read from base+i sits in slice NW-1-i.
  function automatic logic [BW-1:0] model_buf(input logic [15:0] base);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < NW; i++) b[(NW-1-i)*16 +: 16] = mem[16'(base + 16'(i))];
    return b;
  endfunction

  task automatic fill_rand(input logic [15:0] base);
    for (int i = 0; i < NW; i++) mem[16'(base + 16'(i))] = 16'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (addr[g] !== 16'h0 || rd[g] !== 1'b0 || busy[g] !== 1'b0 || done[g] !== 1'b0 || buff[g] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: addr=%h rd=%b busy=%b done=%b buff=%h required all zero",
                 g, addr[g], rd[g], busy[g], done[g], buff[g]);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rd[g] !== 1'b0 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_start dut%0d: rd=%b busy=%b done=%b required 0", g, rd[g], busy[g], done[g]);
      end
    end
  endtask

  // One burst observed on all three latencies; smask bit c drives Start in cycle c.
  task automatic test_burst(input string tag, input logic [15:0] base, input logic [31:0] smask,
                            input bit chk_lit);
    logic [BW-1:0] exp;
    logic [BW-1:0] lit;
    int            ndone [3];
    exp = model_buf(base);
    lit = 256'h0011002200330044005500660077008800990012002300340045005600670078;
    for (int g = 0; g < 3; g++) ndone[g] = 0;
    @(negedge clk);
    start   = 1'b1;
    addr_in = base;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start   = smask[c];
      addr_in = 16'($urandom);
      for (int g = 0; g < 3; g++) begin
        int          dc;
        logic [15:0] ea;
        dc = NW + lat_of(g) + 1;
        ea = (c <= NW) ? 16'(base + 16'(c - 1)) : 16'(base + 16'(NW - 1));
        if (done[g] === 1'b1) ndone[g]++;
        checks++;
        if (rd[g] !== 1'(c <= NW)) begin
          errors++;
          $display("FAIL %s_rd dut%0d cyc%0d: got %b required %b", tag, g, c, rd[g], (c <= NW));
        end
        checks++;
        if (addr[g] !== ea) begin
          errors++;
          $display("FAIL %s_addr dut%0d cyc%0d: got %h required %h", tag, g, c, addr[g], ea);
        end
        checks++;
        if (busy[g] !== 1'(c <= dc)) begin
          errors++;
          $display("FAIL %s_busy dut%0d cyc%0d: got %b required %b", tag, g, c, busy[g], (c <= dc));
        end
        checks++;
        if (done[g] !== 1'(c == dc)) begin
          errors++;
          $display("FAIL %s_done dut%0d cyc%0d: got %b required %b", tag, g, c, done[g], (c == dc));
        end
        if (c == dc) begin
          checks++;
          if (buff[g] !== exp) begin
            errors++;
            $display("FAIL %s_buf dut%0d: got %h required %h", tag, g, buff[g], exp);
          end
          if (chk_lit) begin
            checks++;
            if (buff[g] !== lit) begin
              errors++;
              $display("FAIL %s_buf_const dut%0d: got %h required %h", tag, g, buff[g], lit);
            end
          end
        end
      end
    end
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ndone[g] != 1) begin
        errors++;
        $display("FAIL %s_done_count dut%0d: got %0d required 1", tag, g, ndone[g]);
      end
    end
  endtask

  task automatic test_abort;
    logic [15:0] b;
    b = 16'($urandom);
    fill_rand(b);
    @(negedge clk);
    start   = 1'b1;
    addr_in = b;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (addr[g] !== 16'h0 || rd[g] !== 1'b0 || busy[g] !== 1'b0 || done[g] !== 1'b0 || buff[g] !== '0) begin
        errors++;
        $display("FAIL abort_clear dut%0d: addr=%h rd=%b busy=%b done=%b buff=%h required all zero",
                 g, addr[g], rd[g], busy[g], done[g], buff[g]);
      end
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (done[g] !== 1'b0 || busy[g] !== 1'b0) begin
          errors++;
          $display("FAIL abort_quiet dut%0d cyc%0d: done=%b busy=%b required 0", g, c, done[g], busy[g]);
        end
      end
    end
    fill_rand(16'h0100);
    test_burst("after_abort", 16'h0100, 32'h0, 1'b0);
  endtask

  // Start held high on the RD_LAT=1 instance: burst period is NW+3 cycles.
  task automatic test_back_to_back;
    logic [15:0]   base;
    logic [15:0]   bnext;
    logic [BW-1:0] exp;
    logic [BW-1:0] exp_next;
    int            ndone;
    ndone = 0;
    base  = 16'($urandom);
    bnext = base;
    fill_rand(base);
    exp      = model_buf(base);
    exp_next = exp;
    @(negedge clk);
    start   = 1'b1;
    addr_in = base;
    for (int b = 0; b < 3; b++) begin
      for (int c = 1; c <= NW + 3; c++) begin
        logic [15:0] ea;
        @(negedge clk);
        ea = (c <= NW) ? 16'(base + 16'(c - 1)) : 16'(base + 16'(NW - 1));
        if (done[1] === 1'b1) ndone++;
        checks++;
        if (rd[1] !== 1'(c <= NW) || addr[1] !== ea) begin
          errors++;
          $display("FAIL b2b_issue burst%0d cyc%0d: rd=%b addr=%h required rd=%b addr=%h",
                   b, c, rd[1], addr[1], (c <= NW), ea);
        end
        checks++;
        if (busy[1] !== 1'(c <= NW + 2) || done[1] !== 1'(c == NW + 2)) begin
          errors++;
          $display("FAIL b2b_ctrl burst%0d cyc%0d: busy=%b done=%b required busy=%b done=%b",
                   b, c, busy[1], done[1], (c <= NW + 2), (c == NW + 2));
        end
        if (c == NW + 2) begin
          checks++;
          if (buff[1] !== exp) begin
            errors++;
            $display("FAIL b2b_buf burst%0d: got %h required %h", b, buff[1], exp);
          end
        end
        if (c == NW + 1 && b < 2) begin
          bnext = 16'($urandom);
          fill_rand(bnext);
          exp_next = model_buf(bnext);
          addr_in  = bnext;
        end
        if (c == NW + 3 && b == 2) start = 1'b0;
      end
      base = bnext;
      exp  = exp_next;
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done[1] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 3", ndone);
    end
  endtask

  initial begin
    logic [15:0] img [NW];
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    addr_in = 16'h0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
    img = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088,
            16'h0099, 16'h0012, 16'h0023, 16'h0034, 16'h0045, 16'h0056, 16'h0067, 16'h0078};

    test_reset();

    for (int i = 0; i < NW; i++) mem[16'h0080 + i] = img[i];
    test_burst("basic", 16'h0080, 32'h0, 1'b1);

    for (int i = 0; i < NW; i++) mem[16'(16'hFFF8 + 16'(i))] = 16'(16'hFFF8 + 16'(i));
    test_burst("wrap", 16'hFFF8, 32'h0, 1'b0);

    fill_rand(16'h1234);
    test_burst("restart_ignored", 16'h1234, (32'h1 << 5) | (32'h1 << 17), 1'b0);

    for (int r = 0; r < 4; r++) begin
      logic [15:0] b;
      b = 16'($urandom);
      fill_rand(b);
      test_burst("random", b, 32'h0, 1'b0);
    end

    test_abort();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
